// File: rtl/pll_lock_ctrl_if.sv
// Control/status bundle between the rPLL lock sequencer and its surroundings.
// master: the sequencer; slave: the PLL/downstream side that feeds lock and requests.
interface pll_lock_ctrl_if;
  logic       pll_lock;
  logic       relock_req;
  logic       pll_reset;
  logic       ready;
  logic       fault;
  logic [2:0] retry_cnt;
  logic [2:0] state;

  modport master (
    input  pll_lock, relock_req,
    output pll_reset, ready, fault, retry_cnt, state
  );

  modport slave (
    output pll_lock, relock_req,
    input  pll_reset, ready, fault, retry_cnt, state
  );
endinterface

// File: rtl/pll_lock_ctrl.sv
// rPLL reset/lock sequencer on the raw reference clock: pulses RESET, waits for stable LOCK, relocks on loss.
// Optional macro PLL_LOCK_FILTER_EN: lock loss in RUN needs LOSS_FILTER_CYCLES consecutive low cycles.
module pll_lock_ctrl #(
  parameter int RST_CYCLES          = 32,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 270000,
  parameter int MAX_RETRIES         = 3,
  parameter int LOSS_FILTER_CYCLES  = 4
) (
  input  logic             clkin,
  input  logic             rst_n,
  pll_lock_ctrl_if.master  bus
);

  localparam int MAX_AB  = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CNT = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  if (RST_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 ||
      MAX_RETRIES < 1 || MAX_RETRIES > 7 || LOSS_FILTER_CYCLES < 1) begin : g_bad_params
    $error("pll_lock_ctrl: parameter out of range");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       retry_q, retry_d;
  logic             sync1_q, lock_s;
  logic             lock_lost;
  logic             pll_reset_q, ready_q, fault_q;

  // LOCK is asynchronous to clkin; two flops before anything looks at it.
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      sync1_q <= bus.pll_lock;
      lock_s  <= sync1_q;
    end
  end

`ifdef PLL_LOCK_FILTER_EN
  localparam int LOSS_W = $clog2(LOSS_FILTER_CYCLES + 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_FILTER_CYCLES - 1);

  logic [LOSS_W-1:0] loss_q, loss_d;

  // Count of consecutive low lock_s cycles in RUN; zero everywhere else, so entry to RUN starts clean.
  always_comb begin
    loss_d    = '0;
    lock_lost = 1'b0;
    if (state_q == RUN && !lock_s) begin
      if (loss_q == LOSS_LAST) lock_lost = 1'b1;
      else                     loss_d    = loss_q + 1'b1;
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) loss_q <= '0;
    else        loss_q <= loss_d;
  end
`else
  assign lock_lost = (state_q == RUN) && !lock_s;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_d   = cnt_q + 1'b1;

    if (bus.relock_req) begin
      state_d = RESET_PLL;
      retry_d = '0;
    end else begin
      case (state_q)
        RESET_PLL: if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
          end else if (cnt_q == TMO_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = FAULT;
            end else begin
              state_d = RESET_PLL;
              retry_d = retry_q + 3'd1;
            end
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == STB_LAST) begin
            state_d = RUN;
            retry_d = '0;
          end
        end
        RUN:     if (lock_lost) state_d = RESET_PLL;
        FAULT:   ;
        default: state_d = RESET_PLL;
      endcase
    end

    // The shared counter restarts on any state change or request; it idles at zero in RUN/FAULT.
    if (bus.relock_req || state_d != state_q || state_q == RUN || state_q == FAULT)
      cnt_d = '0;
  end

  // Outputs are decoded from the next state so they move on the same edge as state.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= (state_d == RESET_PLL) || (state_d == FAULT);
      ready_q     <= (state_d == RUN);
      fault_q     <= (state_d == FAULT);
    end
  end

  assign bus.pll_reset = pll_reset_q;
  assign bus.ready     = ready_q;
  assign bus.fault     = fault_q;
  assign bus.retry_cnt = retry_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed + randomized bench for pll_lock_ctrl against a countdown/queue reference model.
// Build with +define+PLL_LOCK_FILTER_EN to exercise the lock-loss filter.
module tb_pll_lock_ctrl;

  localparam int RST_CYCLES          = 4;
  localparam int LOCK_STABLE_CYCLES  = 8;
  localparam int LOCK_TIMEOUT_CYCLES = 20;
  localparam int MAX_RETRIES         = 2;
  localparam int LOSS_FILTER_CYCLES  = 4;

  // Published state encodings
  localparam int P_RESET  = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_RUN    = 3;
  localparam int P_FAULT  = 4;

  logic clkin = 1'b0;
  logic rst_n = 1'b1;

  pll_lock_ctrl_if bus ();

  pll_lock_ctrl #(
    .RST_CYCLES         (RST_CYCLES),
    .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
    .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
    .MAX_RETRIES        (MAX_RETRIES),
    .LOSS_FILTER_CYCLES (LOSS_FILTER_CYCLES)
  ) dut (
    .clkin(clkin),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clkin = ~clkin;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase, cycles left in the current phase, retries, dip length, lock delay line.
  int   m_phase, m_left, m_retries, m_dips;
  logic lq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase   = P_RESET;
    m_left    = RST_CYCLES;
    m_retries = 0;
    m_dips    = 0;
    lq        = {1'b0, 1'b0};
  endtask

  task automatic enter_reset();
    m_phase = P_RESET;
    m_left  = RST_CYCLES;
  endtask

  task automatic model_step(input logic lock_in, input logic req);
    logic ls;
    ls = lq.pop_front();
    lq.push_back(lock_in);
    if (req) begin
      enter_reset();
      m_retries = 0;
    end else begin
      case (m_phase)
        P_RESET: begin
          m_left--;
          if (m_left == 0) begin m_phase = P_WAIT; m_left = LOCK_TIMEOUT_CYCLES; end
        end
        P_WAIT: begin
          if (ls) begin
            m_phase = P_STABLE; m_left = LOCK_STABLE_CYCLES;
          end else begin
            m_left--;
            if (m_left == 0) begin
              if (m_retries == MAX_RETRIES) m_phase = P_FAULT;
              else begin m_retries++; enter_reset(); end
            end
          end
        end
        P_STABLE: begin
          if (!ls) begin
            m_phase = P_WAIT; m_left = LOCK_TIMEOUT_CYCLES;
          end else begin
            m_left--;
            if (m_left == 0) begin m_phase = P_RUN; m_retries = 0; m_dips = 0; end
          end
        end
        P_RUN: begin
`ifdef PLL_LOCK_FILTER_EN
          if (ls) m_dips = 0;
          else begin
            m_dips++;
            if (m_dips == LOSS_FILTER_CYCLES) begin m_dips = 0; enter_reset(); end
          end
`else
          if (!ls) enter_reset();
`endif
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_model();
    check("state",     32'(bus.state),     32'(m_phase));
    check("pll_reset", 32'(bus.pll_reset), 32'(m_phase == P_RESET || m_phase == P_FAULT));
    check("ready",     32'(bus.ready),     32'(m_phase == P_RUN));
    check("fault",     32'(bus.fault),     32'(m_phase == P_FAULT));
    check("retry_cnt", 32'(bus.retry_cnt), 32'(m_retries));
    check("ready_while_reset", 32'(bus.ready & bus.pll_reset), 32'd0);
  endtask

  // Called between edges: drive inputs, take one clock, advance model, sample 1 time unit later.
  task automatic cycle(input logic lock_in, input logic req);
    bus.pll_lock   = lock_in;
    bus.relock_req = req;
    @(posedge clkin);
    model_step(lock_in, req);
    #1 compare_model();
  endtask

  task automatic wait_state(input int target, input logic lock_in, input int max, output int n);
    n = 0;
    do begin
      cycle(lock_in, 1'b0);
      n++;
    end while (int'(bus.state) != target && n < max);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n_hi;
    bus.pll_lock   = 1'b0;
    bus.relock_req = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #1 model_reset();
    compare_model();
    @(negedge clkin);
    rst_n = 1'b1;

    // 1: power-up sequence, reset pulse length and lock-to-ready latency
    n_hi = 1;
    do begin
      cycle(1'b0, 1'b0);
      if (bus.pll_reset) n_hi++;
    end while (bus.pll_reset && n_hi < 50);
    check("rst_pulse_len", 32'(n_hi), 32'(RST_CYCLES));
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    wait_state(P_RUN, 1'b1, 100, n);
    check("lock_to_ready", 32'(n), 32'(3 + LOCK_STABLE_CYCLES));
    check("retry_at_run", 32'(bus.retry_cnt), 32'd0);

`ifndef PLL_LOCK_FILTER_EN
    // 3: single-cycle dip in RUN drops ready three cycles later, then full relock
    cycle(1'b0, 1'b0);
    n = 1;
    while (bus.ready && n < 20) begin cycle(1'b1, 1'b0); n++; end
    check("dip_to_ready_fall", 32'(n), 32'd3);
    wait_state(P_RUN, 1'b1, 100, n);
    check("relock_after_dip", 32'(bus.ready), 32'd1);
`else
    // 6: 3-cycle dip is filtered; 4-cycle dip drops ready
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);
    check("short_dip_ready", 32'(bus.ready), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
    wait_state(P_RESET, 1'b1, 20, n);
    check("long_dip_to_reset", 32'(n), 32'd2);
    wait_state(P_RUN, 1'b1, 100, n);
    check("relock_after_long_dip", 32'(bus.ready), 32'd1);
`endif

    // 4: dip at stable count 5 returns to WAIT_LOCK, then a full stable window
    cycle(1'b1, 1'b1);
    wait_state(P_STABLE, 1'b1, 50, n);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("stable_dip_state", 32'(bus.state), 32'(P_WAIT));
    wait_state(P_RUN, 1'b1, 100, n);
    check("stable_restart_len", 32'(n), 32'(LOCK_STABLE_CYCLES + 1));

    // 2: no lock at all -> two retries then FAULT; lock glitches in FAULT ignored; relock clears
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    wait_state(P_FAULT, 1'b0, 300, n);
    check("time_to_fault", 32'(n), 32'(3 * (RST_CYCLES + LOCK_TIMEOUT_CYCLES)));
    check("fault_retry_cnt", 32'(bus.retry_cnt), 32'(MAX_RETRIES));
    for (int i = 0; i < 6; i++) cycle(1'(i % 2), 1'b0);
    check("fault_sticky", 32'(bus.fault), 32'd1);
    cycle(1'b0, 1'b1);
    check("relock_clears", 32'({bus.fault, bus.retry_cnt, bus.state}), 32'd0);

    // 5: async reset mid-STABLE, then relock_req mid-RESET_PLL restarts the pulse
    wait_state(P_STABLE, 1'b1, 100, n);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_model();
    @(negedge clkin);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    n_hi = 1;
    do begin
      cycle(1'b1, 1'b0);
      if (bus.pll_reset) n_hi++;
    end while (bus.pll_reset && n_hi < 50);
    check("relock_pulse_len", 32'(n_hi), 32'(RST_CYCLES));

    // Randomized lock runs with sparse relock requests
    for (int r = 0; r < 70; r++) begin
      logic lvl;
      int   len;
      lvl = ($urandom_range(0, 9) < 7);
      len = $urandom_range(1, 30);
      for (int i = 0; i < len; i++) cycle(lvl, ($urandom_range(0, 149) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
